// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_pkg
// Brief  : Geometry, derived field widths and refill FSM encoding shared by
//          the direct-mapped cache and its refill controller.
// Rev    : 1.0
// ============================================================================
package cache_pkg;

    localparam int BLOCK_SIZE             = 4;
    localparam int NUM_OF_BLOCKS_PER_LINE = 2;
    localparam int NUM_OF_CACHE_LINES     = 4;
    localparam int ADDRESS_SIZE           = 16;

    localparam int BLOCK_OFFSET_LENGTH = $clog2(NUM_OF_BLOCKS_PER_LINE);
    localparam int INDEX_LENGTH        = $clog2(NUM_OF_CACHE_LINES);
    localparam int TAG_LENGTH          = ADDRESS_SIZE - INDEX_LENGTH - BLOCK_OFFSET_LENGTH;
    localparam int LINE_DATA_LENGTH    = BLOCK_SIZE * NUM_OF_BLOCKS_PER_LINE;
    localparam int CACHE_LINE_LENGTH   = 2 + TAG_LENGTH + LINE_DATA_LENGTH;

    // Line layout: {dirty, valid, tag, block[N-1..0]}
    localparam int DIRTY_BIT_INDEX = CACHE_LINE_LENGTH - 1;
    localparam int VALID_BIT_INDEX = CACHE_LINE_LENGTH - 2;
    localparam int TAG_INDEX       = LINE_DATA_LENGTH;

    // One extra bit so a full line's worth of beats is always representable
    localparam int BEAT_CNT_LENGTH = BLOCK_OFFSET_LENGTH + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        INSTALL   = 2'd3
    } refill_state_e;

endpackage
`default_nettype wire

// File: rtl/cache_refill_controller.sv
`default_nettype none
// ============================================================================
// Module : cache_refill_controller
// Brief  : Miss handler: writes back a dirty victim, fetches the missing line
//          block by block and installs it. Optional critical-word-first fetch
//          enabled by defining CACHE_CRITICAL_WORD_FIRST_EN.
// Rev    : 1.0
// ============================================================================
module cache_refill_controller
    import cache_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         miss_i,
    input  logic [ADDRESS_SIZE-1:0]      address_i,
    input  logic [CACHE_LINE_LENGTH-1:0] victim_line_i,
    output logic [CACHE_LINE_LENGTH-1:0] line_o,
    output logic                         write_line_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [ADDRESS_SIZE-1:0]      mem_addr_o,
    output logic [BLOCK_SIZE-1:0]        mem_wdata_o,
    input  logic [BLOCK_SIZE-1:0]        mem_rdata_i,
    input  logic                         mem_ack_i,
    output logic                         crit_valid_o,
    output logic [BLOCK_SIZE-1:0]        crit_data_o
);

    refill_state_e                  r_state;
    refill_state_e                  w_state_next;
    logic [TAG_LENGTH-1:0]          r_req_tag;
    logic [INDEX_LENGTH-1:0]        r_index;
    logic [TAG_LENGTH-1:0]          r_vic_tag;
    logic [LINE_DATA_LENGTH-1:0]    r_vic_data;
    logic [LINE_DATA_LENGTH-1:0]    r_buf;
    logic [BLOCK_OFFSET_LENGTH-1:0] r_cnt;
    logic [BLOCK_OFFSET_LENGTH-1:0] r_fetch_start;
    logic [BEAT_CNT_LENGTH-1:0]     r_beats;
    logic [BLOCK_OFFSET_LENGTH-1:0] w_start_new;
    logic                           w_vic_dirty;
    logic                           w_last_beat;

    assign w_vic_dirty = victim_line_i[DIRTY_BIT_INDEX] & victim_line_i[VALID_BIT_INDEX];
    assign w_last_beat = (r_beats == BEAT_CNT_LENGTH'(NUM_OF_BLOCKS_PER_LINE - 1));
    assign busy_o      = (r_state != IDLE);

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    assign w_start_new = address_i[BLOCK_OFFSET_LENGTH-1:0];
`else
    logic w_unused_offset;
    assign w_start_new     = '0;
    assign w_unused_offset = ^address_i[BLOCK_OFFSET_LENGTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_req_tag     <= '0;
            r_index       <= '0;
            r_vic_tag     <= '0;
            r_vic_data    <= '0;
            r_buf         <= '0;
            r_cnt         <= '0;
            r_fetch_start <= '0;
            r_beats       <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (miss_i) begin
                        r_req_tag     <= address_i[ADDRESS_SIZE-1 -: TAG_LENGTH];
                        r_index       <= address_i[BLOCK_OFFSET_LENGTH +: INDEX_LENGTH];
                        r_vic_tag     <= victim_line_i[TAG_INDEX +: TAG_LENGTH];
                        r_vic_data    <= victim_line_i[LINE_DATA_LENGTH-1:0];
                        r_buf         <= '0;
                        r_beats       <= '0;
                        r_fetch_start <= w_start_new;
                        // Writeback always runs from block 0 upward
                        r_cnt         <= w_vic_dirty ? '0 : w_start_new;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_beats <= w_last_beat ? '0 : r_beats + 1'b1;
                        r_cnt   <= w_last_beat ? r_fetch_start : r_cnt + 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_ack_i) begin
                        r_buf[r_cnt*BLOCK_SIZE +: BLOCK_SIZE] <= mem_rdata_i;
                        r_beats <= w_last_beat ? '0 : r_beats + 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        line_o       = '0;
        write_line_o = 1'b0;
        done_o       = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        case (r_state)
            IDLE: begin
                if (miss_i)
                    w_state_next = w_vic_dirty ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {r_vic_tag, r_index, r_cnt};
                mem_wdata_o = r_vic_data[r_cnt*BLOCK_SIZE +: BLOCK_SIZE];
                if (mem_ack_i && w_last_beat)
                    w_state_next = FETCH;
            end
            FETCH: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {r_req_tag, r_index, r_cnt};
                if (mem_ack_i && w_last_beat)
                    w_state_next = INSTALL;
            end
            INSTALL: begin
                write_line_o = 1'b1;
                done_o       = 1'b1;
                line_o       = {1'b0, 1'b1, r_req_tag, r_buf};
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    logic                  r_crit_valid;
    logic [BLOCK_SIZE-1:0] r_crit_data;

    // The first acked fetch beat is the requested block
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
        end else begin
            r_crit_valid <= (r_state == FETCH) && mem_ack_i && (r_beats == '0);
            if ((r_state == FETCH) && mem_ack_i && (r_beats == '0))
                r_crit_data <= mem_rdata_i;
        end
    end

    assign crit_valid_o = r_crit_valid;
    assign crit_data_o  = r_crit_data;
`else
    assign crit_valid_o = 1'b0;
    assign crit_data_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_refill_controller
// Brief  : Self-checking bench: directed table, mid-refill reset, held miss
//          and randomized misses against a behavioural memory/refill model.
// Rev    : 1.0
// ============================================================================
module tb_cache_refill_controller;
    import cache_pkg::*;

    localparam int NB    = NUM_OF_BLOCKS_PER_LINE;
    localparam int NL    = NUM_OF_CACHE_LINES;
    localparam int BS    = BLOCK_SIZE;
    localparam int TAGW  = ADDRESS_SIZE - $clog2(NB) - $clog2(NL);
    localparam int DATAW = NB * BS;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         miss_i;
    logic [ADDRESS_SIZE-1:0]      address_i;
    logic [CACHE_LINE_LENGTH-1:0] victim_line_i;
    logic [CACHE_LINE_LENGTH-1:0] line_o;
    logic                         write_line_o;
    logic                         busy_o;
    logic                         done_o;
    logic                         mem_req_o;
    logic                         mem_we_o;
    logic [ADDRESS_SIZE-1:0]      mem_addr_o;
    logic [BS-1:0]                mem_wdata_o;
    logic [BS-1:0]                mem_rdata_i;
    logic                         mem_ack_i;
    logic                         crit_valid_o;
    logic [BS-1:0]                crit_data_o;

    always #5 clk = ~clk;

    cache_refill_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_i        (miss_i),
        .address_i     (address_i),
        .victim_line_i (victim_line_i),
        .line_o        (line_o),
        .write_line_o  (write_line_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_ack_i     (mem_ack_i),
        .crit_valid_o  (crit_valid_o),
        .crit_data_o   (crit_data_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [BS-1:0] mem [int];

    typedef struct { bit we; int addr; int data; } beat_t;
    beat_t exp_q[$];

    typedef struct {
        int          addr;
        int          victim;
        int          waits;
        logic [63:0] exp_line;
        int          exp_lat;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [BS-1:0] mem_read(input int a);
        if (mem.exists(a))
            return mem[a];
        return BS'((a * 5 + 3) ^ (a >> 3));
    endfunction

    function automatic int make_victim(input int dirty, input int valid, input int tag, input int data);
        return (dirty << (DATAW + TAGW + 1)) | (valid << (DATAW + TAGW)) | (tag << DATAW) | data;
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n  = 1'b0;
        miss_i = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one miss from IDLE to the cycle after install, acting as the memory.
    task automatic refill(input int addr, input int victim, input int waits, input bit hold,
                          output int lat, output logic [63:0] line);
        int          tag, idx, off, vtag, start, k, waited, nbeats;
        int          crit_n, crit_c, ack_c;
        logic [BS-1:0] crit_d, crit_or, bd, exp_crit;
        bit          dirty;
        logic [63:0] exp_line;
        beat_t       e;

        tag   = addr / (NB * NL);
        idx   = (addr / NB) % NL;
        off   = addr % NB;
        vtag  = (victim >> DATAW) % (1 << TAGW);
        dirty = ((victim >> (DATAW + TAGW)) & 3) == 3;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        start = off;
`else
        start = 0;
`endif
        exp_q.delete();
        if (dirty)
            for (int b = 0; b < NB; b++)
                exp_q.push_back('{1'b1, (vtag * NL + idx) * NB + b, (victim >> (b * BS)) % (1 << BS)});
        exp_line = (64'd1 << (DATAW + TAGW)) | (64'(tag) << DATAW);
        exp_crit = '0;
        for (int j = 0; j < NB; j++) begin
            k = (start + j) % NB;
            exp_q.push_back('{1'b0, (tag * NL + idx) * NB + k, 0});
            bd = (dirty && vtag == tag) ? BS'(victim >> (k * BS)) : mem_read((tag * NL + idx) * NB + k);
            exp_line = exp_line | (64'(bd) << (k * BS));
            if (j == 0)
                exp_crit = bd;
        end
        nbeats = exp_q.size();

        check("idle_busy", {busy_o, write_line_o, mem_req_o}, 0);
        miss_i        = 1'b1;
        address_i     = ADDRESS_SIZE'(addr);
        victim_line_i = CACHE_LINE_LENGTH'(victim);
        mem_ack_i     = 1'($urandom);
        mem_rdata_i   = BS'($urandom);
        @(posedge clk);
        @(negedge clk);
        if (!hold)
            miss_i = 1'b0;

        waited = 0; crit_n = 0; crit_c = -1; ack_c = -1; crit_d = '0; crit_or = '0; lat = -1;
        for (int c = 1; c <= 400; c++) begin
            mem_ack_i = 1'b0;
            crit_or   = crit_or | crit_data_o;
            if (crit_valid_o) begin
                crit_n++;
                crit_d = crit_data_o;
                crit_c = c;
            end
            if (write_line_o) begin
                lat = c;
                break;
            end
            if (exp_q.size() == 0) begin
                check("extra_beat", {mem_req_o, busy_o}, 2'b01);
            end else begin
                e = exp_q[0];
                check("beat", {mem_req_o, mem_we_o, busy_o, write_line_o, line_o, mem_addr_o,
                               (e.we ? mem_wdata_o : BS'(0))},
                      {1'b1, e.we, 1'b1, 1'b0, {CACHE_LINE_LENGTH{1'b0}}, ADDRESS_SIZE'(e.addr), BS'(e.data)});
                if (mem_req_o) begin
                    if (waited >= waits) begin
                        mem_ack_i = 1'b1;
                        if (mem_we_o) begin
                            mem[int'(mem_addr_o)] = mem_wdata_o;
                        end else begin
                            mem_rdata_i = mem_read(int'(mem_addr_o));
                            if (ack_c < 0)
                                ack_c = c;
                        end
                        void'(exp_q.pop_front());
                        waited = 0;
                    end else begin
                        mem_rdata_i = BS'($urandom);
                        waited++;
                    end
                end
            end
            @(posedge clk);
            @(negedge clk);
        end

        line = 64'(line_o);
        if (lat < 0) begin
            check("timeout", write_line_o, 1);
            do_reset(2);
        end else begin
            check("install", {write_line_o, done_o, busy_o, mem_req_o, line_o}, {4'b1110, exp_line[CACHE_LINE_LENGTH-1:0]});
            check("latency", lat, nbeats * (waits + 1) + 1);
            check("beats_left", exp_q.size(), 0);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
            check("crit_count", crit_n, 1);
            check("crit_data", crit_d, exp_crit);
            check("crit_time", crit_c, ack_c + 1);
`else
            check("crit_off", {crit_n, crit_or, crit_d}, 0);
`endif
            mem_ack_i = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("post_install", {write_line_o, done_o, busy_o, mem_req_o, line_o}, 0);
        end
    endtask

    int          lat;
    logic [63:0] line;
    bit          seen;
    int          r_addr, r_vt, r_victim;

    initial begin
        vecs[0] = '{32'h0025, 0,                          0, 64'h2004BA, 3};
        vecs[1] = '{32'h0024, make_victim(1, 1, 7, 'h5C), 0, 64'h2004BA, 5};
        vecs[2] = '{32'h0025, make_victim(0, 1, 9, 'h33), 0, 64'h2004BA, 3};
        vecs[3] = '{32'h0025, 0,                          3, 64'h2004BA, 9};
        vecs[4] = '{32'h0024, make_victim(1, 1, 7, 'h5C), 2, 64'h2004BA, 13};
        mem[32'h24] = 4'hA;
        mem[32'h25] = 4'hB;

        rst_n = 1'b0; miss_i = 1'b1; address_i = '0; victim_line_i = '1;
        mem_ack_i = 1'b1; mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {line_o, write_line_o, busy_o, done_o, mem_req_o, mem_we_o,
                                mem_addr_o, mem_wdata_o, crit_valid_o, crit_data_o}, 0);
        miss_i = 1'b0; mem_ack_i = 1'b0; rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            refill(vecs[i].addr, vecs[i].victim, vecs[i].waits, 1'b0, lat, line);
            check("vec_line", line, vecs[i].exp_line);
            check("vec_latency", lat, vecs[i].exp_lat);
        end
        check("wb_mem", {mem_read(32'h3C), mem_read(32'h3D)}, 8'hC5);

        // Reset during FETCH after the first beat has been acked
        miss_i = 1'b1; address_i = 16'h0025; victim_line_i = '0;
        @(posedge clk);
        @(negedge clk);
        miss_i = 1'b0;
        check("rst_pre_fetch", {busy_o, mem_req_o, mem_we_o}, 3'b110);
        mem_ack_i = 1'b1; mem_rdata_i = 4'hA;
        @(posedge clk);
        @(negedge clk);
        mem_ack_i = 1'b0;
        check("rst_second_beat", {busy_o, mem_req_o, mem_addr_o}, {2'b11, 16'h0025});
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid", {busy_o, mem_req_o, write_line_o, done_o, line_o}, 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | write_line_o | busy_o;
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_no_install", seen, 0);

        // miss_i held across a refill: one install, re-accepted only from IDLE
        refill(32'h0025, make_victim(1, 1, 3, 'h96), 1, 1'b1, lat, line);
        refill(32'h0125, 0, 0, 1'b0, lat, line);

        for (int i = 0; i < 40; i++) begin
            r_addr = int'($urandom_range(0, 65535));
            r_vt   = (i % 5 == 0) ? r_addr / (NB * NL) : int'($urandom_range(0, (1 << TAGW) - 1));
            r_victim = make_victim(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), r_vt,
                                   int'($urandom_range(0, (1 << DATAW) - 1)));
            refill(r_addr, r_victim, int'($urandom_range(0, 2)), (i < 39) ? 1'($urandom) : 1'b0, lat, line);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
